hazard_ctrl_unit: RTL

- Parametrised hazard/forwarding controller for the 5-stage pipeline (D/E/M/W), the successor to the combinational fwd/stall/condep logic in the control unit.
- Adds W-stage forwarding, a multi-cycle load-use stall counter, a multi-cycle-op (mul/div) scoreboard with a busy counter, and a multi-cycle branch flush counter.
- Sits beside the decode stage and drives the PC/IF-ID write-enables, the ID/EX bubble insertion and the operand-select muxes.

---
 rtl/hazard_ctrl_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
//   Hazard / forwarding controller for the D/E/M/W pipeline. It sits beside
//   decode and produces the operand-select muxes, the PC/IF-ID hold plus
//   ID/EX bubble (Stall), and the IF/ID squash (Flush).
//   It also contains:
//     - W-stage forwarding
//     - a multi-cycle load-use stall counter
//     - a one-entry multi-cycle-op scoreboard with a busy counter
//     - a multi-cycle branch flush counter
//
// Ports
//   Clk, Clrn                   clock (rising edge), async active-low reset
//   dValid                      D holds a valid instruction
//   dRs/dRt, dUseRs/dUseRt      D source regs and whether they are read
//   dRd, dWreg, dMc             D destination, writes-reg, is multi-cycle op
//   eRd/mRd/wRd, e/m/wWreg      downstream destinations and write enables
//   eLoad                       E holds a load
//   eBrTaken                    taken branch / jump resolved in E
//   FwdA, FwdB                  operand select: 00 rf, 10 E, 01 M, 11 W
//   Stall                       hold PC + IF/ID, bubble into ID/EX
//   Flush                       squash IF/ID
//   McBusy                      multi-cycle unit occupied
//   StallCnt, FlushCnt          saturating event counters (HZ_STATS_EN only)
//
// Optional feature macro: HZ_STATS_EN

module hazard_ctrl_unit #(
  parameter int RA_W    = 5,
  parameter int LD_LAT  = 1,
  parameter int MC_LAT  = 4,
  parameter int FLUSH_N = 1
) (
  input  logic            Clk,
  input  logic            Clrn,
  input  logic            dValid,
  input  logic [RA_W-1:0] dRs,
  input  logic [RA_W-1:0] dRt,
  input  logic            dUseRs,
  input  logic            dUseRt,
  input  logic [RA_W-1:0] dRd,
  input  logic            dWreg,
  input  logic            dMc,
  input  logic [RA_W-1:0] eRd,
  input  logic [RA_W-1:0] mRd,
  input  logic [RA_W-1:0] wRd,
  input  logic            eWreg,
  input  logic            mWreg,
  input  logic            wWreg,
  input  logic            eLoad,
  input  logic            eBrTaken,
  output logic [1:0]      FwdA,
  output logic [1:0]      FwdB,
  output logic            Stall,
  output logic            Flush,
  output logic            McBusy
`ifdef HZ_STATS_EN
  ,
  output logic [15:0]     StallCnt,
  output logic [15:0]     FlushCnt
`endif
);

  localparam logic [2:0] LD_RL = 3'(LD_LAT - 1);
  localparam logic [3:0] MC_RL = 4'(MC_LAT);
  localparam logic [1:0] FL_RL = 2'(FLUSH_N - 1);

  logic [2:0]      r_ldcnt;
  logic [3:0]      r_mccnt;
  logic [1:0]      r_flcnt;
  logic            r_pv;
  logic [RA_W-1:0] r_prd;

  logic w_e_rs, w_m_rs, w_w_rs, w_e_rt, w_m_rt, w_w_rt;
  logic w_ld_haz, w_src_haz, w_struct_haz, w_waw_haz;
  logic w_flush, w_stall, w_issue;

  function automatic logic f_match(input logic wreg, input logic [RA_W-1:0] rd,
                                   input logic [RA_W-1:0] src, input logic use_src);
    return wreg && (rd == src) && (rd != '0) && use_src;
  endfunction

  function automatic logic [1:0] f_fwd(input logic e, input logic m, input logic w);
    if (e)      return 2'b10;
    else if (m) return 2'b01;
    else if (w) return 2'b11;
    else        return 2'b00;
  endfunction

  assign w_e_rs = f_match(eWreg, eRd, dRs, dUseRs);
  assign w_m_rs = f_match(mWreg, mRd, dRs, dUseRs);
  assign w_w_rs = f_match(wWreg, wRd, dRs, dUseRs);
  assign w_e_rt = f_match(eWreg, eRd, dRt, dUseRt);
  assign w_m_rt = f_match(mWreg, mRd, dRt, dUseRt);
  assign w_w_rt = f_match(wWreg, wRd, dRt, dUseRt);

  assign FwdA = f_fwd(w_e_rs, w_m_rs, w_w_rs);
  assign FwdB = f_fwd(w_e_rt, w_m_rt, w_w_rt);

  assign McBusy = (r_mccnt != '0);

  // pv implies prd != 0 and is only meaningful while the op is still running
  assign w_ld_haz     = dValid && eLoad && (w_e_rs || w_e_rt);
  assign w_src_haz    = dValid && r_pv && McBusy &&
                        ((dUseRs && dRs == r_prd) || (dUseRt && dRt == r_prd));
  assign w_struct_haz = dValid && dMc && McBusy;
  assign w_waw_haz    = dValid && dWreg && r_pv && (dRd == r_prd);

  // Outputs are held low during reset even though the hazard terms are
  // combinational on the inputs
  assign w_flush = Clrn && (eBrTaken || (r_flcnt != '0));
  assign w_stall = Clrn && !w_flush &&
                   (w_ld_haz || (r_ldcnt != '0) || w_src_haz || w_struct_haz || w_waw_haz);
  assign w_issue = dValid && dMc && !w_stall && !w_flush;

  assign Stall = w_stall;
  assign Flush = w_flush;

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_ldcnt <= '0;
      r_mccnt <= '0;
      r_flcnt <= '0;
      r_pv    <= 1'b0;
      r_prd   <= '0;
    end else begin
      // a new taken branch restarts the squash window
      if (eBrTaken)              r_flcnt <= FL_RL;
      else if (r_flcnt != '0)    r_flcnt <= r_flcnt - 2'd1;

      // flush squashes the stalled instruction, so its load-use wait is moot
      if (w_flush)               r_ldcnt <= '0;
      else if (w_ld_haz)         r_ldcnt <= LD_RL;
      else if (r_ldcnt != '0)    r_ldcnt <= r_ldcnt - 3'd1;

      // an issued mc op is never cancelled by flush
      if (w_issue) begin
        r_mccnt <= MC_RL;
        r_pv    <= dWreg && (dRd != '0);
        r_prd   <= dRd;
      end else if (r_mccnt != '0) begin
        r_mccnt <= r_mccnt - 4'd1;
        if (r_mccnt == 4'd1) r_pv <= 1'b0;
      end
    end
  end

`ifdef HZ_STATS_EN
  logic [15:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_flush && r_flush_cnt != 16'hFFFF) r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign StallCnt = r_stall_cnt;
  assign FlushCnt = r_flush_cnt;
`else
  // statistics counters not built
`endif

endmodule
